// File: rtl/pwls_reg_writer_pkg.sv
// Shared constants for the PWLS register writer: default data width and the
// header byte layout {cnt[1:0], addr[5:0]}.
package pwls_reg_writer_pkg;

    localparam int unsigned RegBitsDefault = 16;

    localparam int unsigned HdrCntLsb  = 6;
    localparam int unsigned HdrCntW    = 2;
    localparam int unsigned HdrAddrLsb = 0;
    localparam int unsigned HdrAddrW   = 6;

    // Wide enough for the byte index of a 32-bit word.
    localparam int unsigned ByteIdxW = 2;

    function automatic logic [HdrCntW-1:0] hdr_cnt(input logic [7:0] hdr);
        return hdr[HdrCntLsb +: HdrCntW];
    endfunction

    function automatic logic [HdrAddrW-1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HdrAddrLsb +: HdrAddrW];
    endfunction

endpackage

// File: rtl/pwls_reg_writer.sv
// Parses header/data byte frames from the host link and issues single-cycle
// register writes (LSB-first words, auto-incrementing address within a burst).
module pwls_reg_writer
    import pwls_reg_writer_pkg::*;
#(
    parameter int unsigned REG_BITS  = RegBitsDefault,
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sync,
    output logic [ADDR_BITS-1:0] reg_waddr,
    output logic [REG_BITS-1:0]  reg_wdata,
    output logic                 reg_we,
    output logic                 busy
);

    localparam int unsigned NBytes = REG_BITS / 8;
    localparam logic [ByteIdxW-1:0] LastIdx = ByteIdxW'(NBytes - 1);

    if ((REG_BITS % 8) != 0 || REG_BITS < 8 || REG_BITS > 32) begin : g_bad_reg_bits
        $error("REG_BITS must be a multiple of 8 between 8 and 32");
    end

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StIssue
    } state_e;

    state_e                state_q;
    logic [ByteIdxW-1:0]   idx_q;
    logic [HdrCntW-1:0]    words_left_q;
    logic [ADDR_BITS-1:0]  waddr_q;
    logic [REG_BITS-1:0]   wdata_q;
    logic                  we_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            words_left_q <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                StIdle, StData: begin
                    // A resync byte is always a header, even in the middle of a word.
                    if (in_valid && (in_sync || state_q == StIdle)) begin
                        waddr_q      <= ADDR_BITS'(hdr_addr(in_data));
                        words_left_q <= hdr_cnt(in_data);
                        idx_q        <= '0;
                        state_q      <= StData;
                    end else if (in_sync) begin
                        idx_q   <= '0;
                        state_q <= StIdle;
                    end else if (in_valid) begin
                        for (int b = 0; b < NBytes; b++) begin
                            if (idx_q == ByteIdxW'(b)) begin
                                wdata_q[8*b +: 8] <= in_data;
                            end
                        end
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            we_q    <= 1'b1;
                            state_q <= StIssue;
                        end else begin
                            idx_q <= idx_q + ByteIdxW'(1);
                        end
                    end
                end
                StIssue: begin
                    // The write strobe is already out; sync only suppresses the follow-on word.
                    if (in_sync || words_left_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        words_left_q <= words_left_q - HdrCntW'(1);
                        waddr_q      <= waddr_q + ADDR_BITS'(1);
                        state_q      <= StData;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q != StIssue);
    assign busy      = (state_q != StIdle);
    assign reg_we    = we_q;
    assign reg_waddr = waddr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_pwls_reg_writer.sv
// Directed bench for pwls_reg_writer with a shadow register file fed by reg_we.
module tb_pwls_reg_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sync = 1'b0;
    logic [5:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [5:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;

    wr_t         wlog[$];
    logic [15:0] mem[64];

    pwls_reg_writer #(
        .REG_BITS (16),
        .ADDR_BITS(6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sync  (in_sync),
        .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            wlog.push_back('{reg_waddr, reg_wdata, cyc});
            mem[reg_waddr] <= reg_wdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Called at negedge+1; returns at negedge+1 after the transferring posedge.
    task automatic send(input logic [7:0] b, input logic s);
        int g = 0;
        in_data  = b;
        in_valid = 1'b1;
        in_sync  = s;
        while (in_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got %b required 1", in_ready);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", reg_we); end
        n_checks++; if (reg_waddr !== 6'd0) begin n_fail++; $display("FAIL rst_waddr: got %0h required 0", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_wdata: got %0h required 0", reg_wdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", in_ready); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single_write();
        wlog.delete();
        send(8'h05, 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
        send(8'h34, 1'b0);
        send(8'h12, 1'b0);
        n_checks++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b required 1", reg_we); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready: got %b required 0", in_ready); end
        n_checks++; if (reg_waddr !== 6'd5) begin n_fail++; $display("FAIL single_waddr: got %0h required 5", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h1234) begin n_fail++; $display("FAIL single_wdata: got %0h required 1234", reg_wdata); end
        idle(1);
        n_checks++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL single_we_pulse: got %b required 0", reg_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b required 0", busy); end
        n_checks++; if (reg_wdata !== 16'h1234) begin n_fail++; $display("FAIL single_hold: got %0h required 1234", reg_wdata); end
        n_checks++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d required 1", wlog.size()); end
    endtask

    task automatic test_burst_wrap();
        logic [5:0]  ea[4] = '{6'd63, 6'd0, 6'd1, 6'd2};
        logic [15:0] ed[4] = '{16'h2211, 16'h4433, 16'h6655, 16'h8877};
        logic [7:0]  bytes[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        wlog.delete();
        send(8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) send(bytes[i], 1'b0);
        idle(2);
        n_checks++; if (wlog.size() !== 4) begin n_fail++; $display("FAIL burst_count: got %0d required 4", wlog.size()); end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            n_checks++;
            if (wlog[i].a !== ea[i] || wlog[i].d !== ed[i]) begin
                n_fail++;
                $display("FAIL burst_w%0d: got %0d/%0h required %0d/%0h", i, wlog[i].a, wlog[i].d, ea[i], ed[i]);
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_idle: got %b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int viol = 0;
        wlog.delete();
        fork
            begin
                send(8'h41, 1'b0);
                send(8'hAA, 1'b0);
                send(8'hBB, 1'b0);
                send(8'hCC, 1'b0);
                send(8'hDD, 1'b0);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    #1;
                    if (in_ready !== ~reg_we) viol++;
                end
            end
        join
        idle(2);
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL b2b_ready_vs_we: got %0d bad cycles required 0", viol); end
        n_checks++; if (wlog.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d required 2", wlog.size()); end
        if (wlog.size() == 2) begin
            n_checks++;
            if (wlog[0].a !== 6'd1 || wlog[0].d !== 16'hBBAA) begin
                n_fail++; $display("FAIL b2b_w0: got %0d/%0h required 1/bbaa", wlog[0].a, wlog[0].d);
            end
            n_checks++;
            if (wlog[1].a !== 6'd2 || wlog[1].d !== 16'hDDCC) begin
                n_fail++; $display("FAIL b2b_w1: got %0d/%0h required 2/ddcc", wlog[1].a, wlog[1].d);
            end
            n_checks++;
            if (wlog[1].c - wlog[0].c !== 3) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d required 3", wlog[1].c - wlog[0].c);
            end
        end
    endtask

    task automatic test_resync();
        wlog.delete();
        send(8'h02, 1'b0);
        send(8'h34, 1'b0);
        send(8'h07, 1'b1);
        send(8'hCD, 1'b0);
        send(8'hAB, 1'b0);
        idle(2);
        n_checks++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL resync_count: got %0d required 1", wlog.size()); end
        if (wlog.size() == 1) begin
            n_checks++;
            if (wlog[0].a !== 6'd7 || wlog[0].d !== 16'hABCD) begin
                n_fail++; $display("FAIL resync_w: got %0d/%0h required 7/abcd", wlog[0].a, wlog[0].d);
            end
        end
    endtask

    task automatic test_sync_in_issue();
        wlog.delete();
        send(8'h43, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        in_sync = 1'b1;
        idle(1);
        in_sync = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL issync_idle: got %b required 0", busy); end
        n_checks++; if (reg_waddr !== 6'd3) begin n_fail++; $display("FAIL issync_waddr: got %0d required 3", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h0201) begin n_fail++; $display("FAIL issync_wdata: got %0h required 0201", reg_wdata); end
        idle(2);
        n_checks++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL issync_count: got %0d required 1", wlog.size()); end
    endtask

    task automatic test_mid_reset();
        wlog.delete();
        send(8'h03, 1'b0);
        send(8'h99, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy: got %b required 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b required 1", in_ready); end
        n_checks++; if (reg_waddr !== 6'd0) begin n_fail++; $display("FAIL mrst_waddr: got %0d required 0", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h0) begin n_fail++; $display("FAIL mrst_wdata: got %0h required 0", reg_wdata); end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        send(8'h09, 1'b0);
        send(8'h78, 1'b0);
        send(8'h56, 1'b0);
        idle(2);
        n_checks++; if (wlog.size() !== 1) begin n_fail++; $display("FAIL mrst_count: got %0d required 1", wlog.size()); end
        if (wlog.size() == 1) begin
            n_checks++;
            if (wlog[0].a !== 6'd9 || wlog[0].d !== 16'h5678) begin
                n_fail++; $display("FAIL mrst_w: got %0d/%0h required 9/5678", wlog[0].a, wlog[0].d);
            end
        end
    endtask

    task automatic test_regfile();
        n_checks++; if (mem[5] !== 16'h1234) begin n_fail++; $display("FAIL rf5: got %0h required 1234", mem[5]); end
        n_checks++; if (mem[63] !== 16'h2211) begin n_fail++; $display("FAIL rf63: got %0h required 2211", mem[63]); end
        n_checks++; if (mem[0] !== 16'h4433) begin n_fail++; $display("FAIL rf0: got %0h required 4433", mem[0]); end
        n_checks++; if (mem[2] !== 16'hDDCC) begin n_fail++; $display("FAIL rf2: got %0h required ddcc", mem[2]); end
        n_checks++; if (mem[7] !== 16'hABCD) begin n_fail++; $display("FAIL rf7: got %0h required abcd", mem[7]); end
        n_checks++; if (mem[9] !== 16'h5678) begin n_fail++; $display("FAIL rf9: got %0h required 5678", mem[9]); end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_back_to_back();
        test_resync();
        test_sync_in_issue();
        test_mid_reset();
        test_regfile();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
